// File: rtl/systolic_output_collector.sv
// ============================================================================
// Module   : systolic_output_collector
// Brief    : Picks the finished PE result from a systolic array once per
//            input-word slot, drops warm-up partial sums, and buffers the
//            {word, PE index} pairs in a first-word-fall-through FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_output_collector #(
  parameter int WORDLENGTH  = 16,
  parameter int NUM_PE      = 8,
  parameter int SLOT_CYCLES = 30,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                         clk30x,
  input  logic                         reset,
  input  logic [NUM_PE*WORDLENGTH-1:0] pe_bus,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [WORDLENGTH-1:0]        out_word,
  output logic [2:0]                   out_pe_index,
  output logic [3:0]                   fifo_level,
  output logic                         overflow
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                c_sc_w      = $clog2(SLOT_CYCLES);
  localparam int                c_ptr_w     = $clog2(FIFO_DEPTH);
  localparam logic [c_sc_w-1:0] c_slot_last = c_sc_w'(SLOT_CYCLES - 1);
  // Strobes needed before the array pipeline holds a complete result.
  localparam logic [2:0]        c_warm_last = 3'(NUM_PE - 1);
  localparam logic [3:0]        c_fifo_full = 4'(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(FIFO_DEPTH - 1);

  // --------------------------------------------------------------------------
  // Slot timing
  // --------------------------------------------------------------------------
  logic [c_sc_w-1:0]  r_slot_count;
  logic [2:0]         r_slot_index;
  logic [2:0]         r_warm_count;
  logic               w_strobe;
  logic               w_capture;
  logic [2:0]         w_sel_pe;
  logic [WORDLENGTH-1:0] w_sel_word;

  assign w_strobe  = (r_slot_count == c_slot_last);
  assign w_capture = w_strobe && (r_warm_count == c_warm_last);
  // The PE that finishes in this slot is one ahead of the slot index.
  assign w_sel_pe  = r_slot_index + 3'd1;

  // Free-running clock counter inside one input-word slot.
  always_ff @(posedge clk30x) begin
    if (reset) begin
      r_slot_count <= '0;
    end else if (w_strobe) begin
      r_slot_count <= '0;
    end else begin
      r_slot_count <= r_slot_count + 1'b1;
    end
  end

  // Slot index advances once per slot and wraps naturally at 8.
  always_ff @(posedge clk30x) begin
    if (reset) begin
      r_slot_index <= 3'd0;
    end else if (w_strobe) begin
      r_slot_index <= r_slot_index + 3'd1;
    end
  end

  // Saturating warm-up counter: the first NUM_PE-1 strobes carry partial sums.
  always_ff @(posedge clk30x) begin
    if (reset) begin
      r_warm_count <= 3'd0;
    end else if (w_strobe && (r_warm_count != c_warm_last)) begin
      r_warm_count <= r_warm_count + 3'd1;
    end
  end

  // Select the completing PE's word from the packed bus.
  always_comb begin
    w_sel_word = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (w_sel_pe == 3'(k)) begin
        w_sel_word = pe_bus[k*WORDLENGTH +: WORDLENGTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // --------------------------------------------------------------------------
  logic [WORDLENGTH-1:0] r_mem_word [FIFO_DEPTH];
  logic [2:0]            r_mem_idx  [FIFO_DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [3:0]            r_level;
  logic                  r_overflow;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;

  assign w_full = (r_level == c_fifo_full);
  assign w_pop  = out_valid && out_ready;
  // At full a simultaneous pop frees the slot, so the push is still taken.
  assign w_push = w_capture && (!w_full || w_pop);

  // Storage write; reset blocks the write so a reset edge never leaves data.
  always_ff @(posedge clk30x) begin
    if (!reset && w_push) begin
      r_mem_word[r_wr_ptr] <= w_sel_word;
      r_mem_idx[r_wr_ptr]  <= w_sel_pe;
    end
  end

  // Write pointer, modulo FIFO_DEPTH.
  always_ff @(posedge clk30x) begin
    if (reset) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
    end
  end

  // Read pointer, modulo FIFO_DEPTH.
  always_ff @(posedge clk30x) begin
    if (reset) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: unchanged when push and pop coincide.
  always_ff @(posedge clk30x) begin
    if (reset) begin
      r_level <= 4'd0;
    end else if (w_push && !w_pop) begin
      r_level <= r_level + 4'd1;
    end else if (w_pop && !w_push) begin
      r_level <= r_level - 4'd1;
    end
  end

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clk30x) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_capture && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all driven from registers, zero while the FIFO is empty.
  // --------------------------------------------------------------------------
  assign out_valid    = (r_level != 4'd0);
  assign out_word     = out_valid ? r_mem_word[r_rd_ptr] : '0;
  assign out_pe_index = out_valid ? r_mem_idx[r_rd_ptr]  : 3'd0;
  assign fifo_level   = r_level;
  assign overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_systolic_output_collector.sv
// ============================================================================
// Module   : tb_systolic_output_collector
// Brief    : Directed self-checking bench for systolic_output_collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_output_collector;

  localparam int WL  = 16;
  localparam int NPE = 8;

  logic                clk30x = 1'b0;
  logic                reset  = 1'b1;
  logic [NPE*WL-1:0]   pe_bus;
  logic                out_ready = 1'b0;
  logic                out_valid;
  logic [WL-1:0]       out_word;
  logic [2:0]          out_pe_index;
  logic [3:0]          fifo_level;
  logic                overflow;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  systolic_output_collector #(
    .WORDLENGTH (WL),
    .NUM_PE     (NPE),
    .SLOT_CYCLES(30),
    .FIFO_DEPTH (8)
  ) dut (
    .clk30x      (clk30x),
    .reset       (reset),
    .pe_bus      (pe_bus),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_word    (out_word),
    .out_pe_index(out_pe_index),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  // Free-running clock.
  always #5 clk30x = ~clk30x;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk30x);
    #1;
    edge_n++;
  endtask

  // Advance until edge e (counted from 0 after reset release) has occurred.
  task automatic go_to(input int e);
    while (edge_n <= e) step();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk30x);
      #1;
    end
    reset  = 1'b0;
    edge_n = 0;
  endtask

  function automatic int cap(input int j);
    return 239 + 30 * j;
  endfunction

  function automatic logic [31:0] pe_word(input int k);
    return 32'(16'h1000 + 16'(k % 8));
  endfunction

  task automatic check_zero_state(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_word"},  32'(out_word), 32'd0);
    check({tag, "_idx"},   32'(out_pe_index), 32'd0);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_ovf"},   32'(overflow), 32'd0);
  endtask

  task automatic check_no_early_valid(input string tag);
    int seen;
    seen = 0;
    while (edge_n <= 238) begin
      step();
      if (out_valid) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int pops;
    logic held_valid;
    logic [WL-1:0] held_word;

    for (int k = 0; k < NPE; k++) pe_bus[k*WL +: WL] = 16'h1000 + 16'(k);

    // Reset state
    do_reset();
    check_zero_state("reset");

    // First capture, fill to full, then overflow
    check_no_early_valid("first_no_early_valid");
    go_to(cap(0));
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_word",  32'(out_word), pe_word(0));
    check("first_idx",   32'(out_pe_index), 32'd0);
    check("first_level", 32'(fifo_level), 32'd1);
    go_to(cap(7));
    check("full_level", 32'(fifo_level), 32'd8);
    check("full_ovf",   32'(overflow), 32'd0);
    go_to(cap(8));
    check("ovf_level", 32'(fifo_level), 32'd8);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_head_word", 32'(out_word), pe_word(0));
    check("ovf_head_idx",  32'(out_pe_index), 32'd0);

    // Reset with FIFO full and overflow set, then push+pop at full
    do_reset();
    check_zero_state("reset_full");
    go_to(cap(7));
    check("pp_pre_level", 32'(fifo_level), 32'd8);
    go_to(cap(8) - 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pp_level", 32'(fifo_level), 32'd8);
    check("pp_ovf",   32'(overflow), 32'd0);
    check("pp_head_word", 32'(out_word), pe_word(1));
    for (int i = 0; i < 8; i++) begin
      check("pp_drain_word", 32'(out_word), pe_word(i + 1));
      check("pp_drain_idx",  32'(out_pe_index), 32'((i + 1) % 8));
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    check("pp_drained_level", 32'(fifo_level), 32'd0);

    // Sequencing with continuous ready
    do_reset();
    out_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      go_to(cap(j) - 1);
      check("seq_idle", 32'(out_valid), 32'd0);
      go_to(cap(j));
      check("seq_valid", 32'(out_valid), 32'd1);
      check("seq_word",  32'(out_word), pe_word(j));
      check("seq_idx",   32'(out_pe_index), 32'(j % 8));
      step();
      check("seq_one_cycle", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    // Reset mid-operation at slot_count 12 with 5 entries buffered
    do_reset();
    go_to(cap(4));
    check("mid_level5", 32'(fifo_level), 32'd5);
    go_to(371);
    reset = 1'b1;
    step();
    check_zero_state("mid_reset");
    reset  = 1'b0;
    edge_n = 0;
    check_no_early_valid("mid_no_early_valid");
    go_to(cap(0));
    check("mid_recap_valid", 32'(out_valid), 32'd1);
    check("mid_recap_idx",   32'(out_pe_index), 32'd0);
    check("mid_recap_word",  32'(out_word), pe_word(0));

    // Backpressure toggling 1010...
    do_reset();
    pops       = 0;
    held_valid = 1'b0;
    held_word  = '0;
    for (int n = 0; n < 900 && pops < 16; n++) begin
      out_ready = (edge_n % 2 == 0);
      if (held_valid) check("bp_hold", 32'(out_word), 32'(held_word));
      held_valid = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          check("bp_word", 32'(out_word), pe_word(pops));
          check("bp_idx",  32'(out_pe_index), 32'(pops % 8));
          pops++;
        end else begin
          held_valid = 1'b1;
          held_word  = out_word;
        end
      end
      step();
    end
    out_ready = 1'b0;
    check("bp_pops", 32'(pops), 32'd16);
    check("bp_no_dup_level", 32'(fifo_level), 32'd0);
    check("bp_ovf", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/systolic_output_collector.md
SYSTOLIC_OUTPUT_COLLECTOR -- requirements
Module: systolic_output_collector

Interface
REQ-001 SHALL have parameter WORDLENGTH, default 16, sample/result word width.
REQ-002 SHALL have parameter NUM_PE, default 8, number of processing elements in the array; fixed at 8 (3-bit index).
REQ-003 SHALL have parameter SLOT_CYCLES, default 30, clocks per input-word slot.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, output buffer entries.
REQ-005 SHALL have port clk30x, input, 1, clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port pe_bus, input, NUM_PE*WORDLENGTH, packed PE results; PE k occupies bits [k*WORDLENGTH +: WORDLENGTH].
REQ-008 SHALL have port out_ready, input, 1, downstream accepts the word this cycle.
REQ-009 SHALL have port out_valid, output, 1, out_word/out_pe_index hold a buffered result.
REQ-010 SHALL have port out_word, output, WORDLENGTH, head-of-FIFO result.
REQ-011 SHALL have port out_pe_index, output, 3, PE that produced out_word.
REQ-012 SHALL have port fifo_level, output, 4, current FIFO occupancy, 0..FIFO_DEPTH.
REQ-013 SHALL have port overflow, output, 1, sticky flag: a result was dropped.

Function
REQ-014 SHALL run slot_count 0..SLOT_CYCLES-1, incrementing every clock and wrapping 29->0.
REQ-015 SHALL define the strobe as the cycle with slot_count==SLOT_CYCLES-1; slot_index (3-bit) increments on each strobe, wrapping 7->0.
REQ-016 SHALL select the completing PE on a strobe as (slot_index+1) mod 8, using the pre-increment slot_index.
REQ-017 SHALL discard the first NUM_PE-1 strobes after reset (partial sums), via a saturating warm-up counter; every later strobe is a capture.
REQ-018 SHALL, on a capture edge, push {selected PE word, PE index} into the FIFO with no combinational path from pe_bus to outputs.
REQ-019 SHALL be first-word-fall-through: out_valid=1 whenever fifo_level>0; out_word/out_pe_index reflect the head entry.
REQ-020 SHALL pop the head on an edge where out_valid && out_ready; out_ready with out_valid=0 has no effect.
REQ-021 SHALL give 1-cycle latency: entry pushed at edge N into an empty FIFO is visible with out_valid=1 after edge N.
REQ-022 SHALL, on push and pop in the same edge, keep fifo_level unchanged and preserve order; this holds at full (pop frees the slot, push accepted).
REQ-023 SHALL, on push at full with no pop, drop the new entry, leave FIFO contents unchanged, and set overflow=1 until reset.
REQ-024 SHALL keep out_word/out_pe_index stable while out_valid=1 and out_ready=0.
REQ-025 SHALL treat FIFO pointers as modulo FIFO_DEPTH with wrap-around preserving order.

Reset
REQ-026 SHALL, with reset high at an edge, set slot_count=0, slot_index=0, warm-up counter=0, FIFO empty, fifo_level=0, out_valid=0, out_word=0, out_pe_index=0, overflow=0.
REQ-027 SHALL let reset override any concurrent strobe, push or pop, including mid-slot and with FIFO full; counting restarts from 0 on the first edge after release.

Verification
REQ-028 SHALL verify first capture: release reset, pe_bus word k = 16'h1000+k, out_ready=0 -> no out_valid through edge 238 (edge 0 = first after release); at edge 239 capture, out_valid=1 with out_word=16'h1000, out_pe_index=0.
REQ-029 SHALL verify sequencing: out_ready=1 continuously -> results appear every 30 clocks with out_pe_index 0,1,2,...,7,0 and matching words, each held 1 cycle.
REQ-030 SHALL verify full/overflow: out_ready=0 for 8 captures -> fifo_level=8, overflow=0; 9th capture -> fifo_level stays 8, overflow=1, head still PE 0's word.
REQ-031 SHALL verify simultaneous push/pop at full: fifo_level=8, out_ready=1 on a capture edge -> fifo_level=8, overflow=0, new entry appended at tail.
REQ-032 SHALL verify reset mid-operation: fifo_level=5 with reset at slot_count=12 -> next cycle all outputs 0, fifo_level=0; first capture again 240 edges later.
REQ-033 SHALL verify backpressure stability: out_ready toggled 1010... -> out_word unchanged while out_ready=0, no entry lost or duplicated across 16 captures.
